// File: rtl/uart_tx_core.sv
// uart_tx_core -- transmit half of a UART.
// Serialises one parallel word per request into a frame of
// start(0) / data LSB first / optional parity / stop(1) on TX_OUT.
// Every bit lasts Prescale clk cycles, and the baud divider is internal.
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous, active-low reset
//   P_DATA     word to send, sampled on accept
//   Data_Valid request, accepted when the core is idle
//   PAR_EN     1 = append a parity bit, sampled on accept
//   PAR_TYP    0 = even, 1 = odd parity, sampled on accept
//   Prescale   clk cycles per bit (0 and 1 are treated as 2), sampled on accept
//   TX_OUT     registered serial line, idles high
//   busy       registered, high for the whole frame (start through stop)
module uart_tx_core #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRESCALE_W-1:0] Prescale,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                 state_q,    state_d;
   logic                   tx_q,       tx_d;
   logic                   busy_q,     busy_d;
   logic [PRESCALE_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic [BIT_W-1:0]       bit_cnt_q,  bit_cnt_d;
   logic [DATA_WIDTH-1:0]  data_q,     data_d;
   logic                   par_en_q,   par_en_d;
   logic                   par_bit_q,  par_bit_d;
   logic [PRESCALE_W-1:0]  presc_q,    presc_d;
   logic                   period_end;

   assign period_end = (edge_cnt_q == (presc_q - PRESCALE_W'(1)));

   always_comb begin
      state_d    = state_q;
      edge_cnt_d = edge_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      presc_d    = presc_q;
      tx_d       = 1'b1;
      busy_d     = 1'b0;

      case (state_q)
         IDLE: begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
            if (Data_Valid) begin
               data_d    = P_DATA;
               par_en_d  = PAR_EN;
               par_bit_d = PAR_TYP ? ~^P_DATA : ^P_DATA;
               presc_d   = (Prescale < PRESCALE_W'(2)) ? PRESCALE_W'(2) : Prescale;
               state_d   = START;
            end
         end
         START: begin
            edge_cnt_d = period_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
            if (period_end) begin
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            edge_cnt_d = period_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
            if (period_end) begin
               if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            edge_cnt_d = period_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
            if (period_end) state_d = STOP;
         end
         STOP: begin
            edge_cnt_d = period_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
            if (period_end) state_d = IDLE;
         end
         default: begin
            state_d    = IDLE;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
         end
      endcase

      // Outputs are decoded from the next state so the registered TX_OUT/busy
      // change on the same edge as the state register.
      case (state_d)
         START: begin
            tx_d   = 1'b0;
            busy_d = 1'b1;
         end
         DATA: begin
            tx_d   = data_q[bit_cnt_d];
            busy_d = 1'b1;
         end
         PARITY: begin
            tx_d   = par_bit_q;
            busy_d = 1'b1;
         end
         STOP: begin
            tx_d   = 1'b1;
            busy_d = 1'b1;
         end
         default: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         presc_q    <= '0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         presc_q    <= presc_d;
      end
   end

   assign TX_OUT = tx_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core -- scoreboard bench for uart_tx_core.
// Expected per-cycle TX_OUT values are queued when a frame is requested, and
// compared against the line as recorded while busy is high.
module tb_uart_tx_core;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] Prescale;
   logic       TX_OUT;
   logic       busy;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic exp_q[$];
   int   exp_len_q[$];
   logic log_q[$];

   always #5 clk = ~clk;

   uart_tx_core #(
      .DATA_WIDTH (8),
      .PRESCALE_W (6)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   // Reference frame: one queue entry per clk cycle of the frame.
   task automatic push_frame(input logic [7:0] d, input bit pe, input bit pt, input int p);
      int   pp;
      int   ones;
      logic bits[$];
      pp   = (p < 2) ? 2 : p;
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         bits.push_back(d[i]);
         if (d[i]) ones++;
      end
      if (pe) bits.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
      bits.push_back(1'b1);
      foreach (bits[k]) repeat (pp) exp_q.push_back(bits[k]);
      exp_len_q.push_back(bits.size() * pp);
   endtask

   task automatic start_frame(input logic [7:0] d, input bit pe, input bit pt, input int p);
      @(negedge clk);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Prescale   = 6'(p);
      Data_Valid = 1'b1;
      push_frame(d, pe, pt, p);
   endtask

   // Records TX_OUT on every negedge while busy is high; lat = negedges until busy.
   task automatic record_frame(input bit hold, output int lat, output bit tmo);
      bit seen;
      seen = 0;
      tmo  = 0;
      lat  = 0;
      log_q.delete();
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (busy === 1'b1) seen = 1;
      end
      if (!seen) begin
         tmo = 1;
         Data_Valid = 1'b0;
         return;
      end
      if (!hold) Data_Valid = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         log_q.push_back(TX_OUT);
         @(negedge clk);
         if (busy !== 1'b1) return;
      end
      tmo = 1;
   endtask

   task automatic test_reset;
      rst        = 1'b0;
      Data_Valid = 1'b1;
      P_DATA     = 8'hA5;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Prescale   = 6'd4;
      repeat (3) begin
         @(negedge clk);
         chk_cnt++;
         if (TX_OUT !== 1'b1) $display("FAIL reset_tx: TX_OUT %b expected 1", TX_OUT);
         else pass_cnt++;
         chk_cnt++;
         if (busy !== 1'b0) $display("FAIL reset_busy: busy %b expected 0", busy);
         else pass_cnt++;
      end
      Data_Valid = 1'b0;
      rst        = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk_cnt++;
         if (TX_OUT !== 1'b1 || busy !== 1'b0)
            $display("FAIL idle: TX_OUT %b busy %b expected 1 0", TX_OUT, busy);
         else pass_cnt++;
      end
   endtask

   task automatic test_basic;
      int lat, exp_len;
      bit tmo;
      logic e;
      start_frame(8'hA5, 0, 0, 4);
      record_frame(0, lat, tmo);
      chk_cnt++;
      if (tmo) $display("FAIL basic_timeout: timeout %b expected 0", tmo); else pass_cnt++;
      chk_cnt++;
      if (lat != 1) $display("FAIL basic_latency: %0d expected 1", lat); else pass_cnt++;
      exp_len = exp_len_q.pop_front();
      chk_cnt++;
      if (log_q.size() != exp_len)
         $display("FAIL basic_len: busy cycles %0d expected %0d", log_q.size(), exp_len);
      else pass_cnt++;
      for (int i = 0; i < exp_len; i++) begin
         e = exp_q.pop_front();
         if (i < log_q.size()) begin
            chk_cnt++;
            if (log_q[i] !== e) $display("FAIL basic_bit: cycle %0d TX_OUT %b expected %b", i, log_q[i], e);
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (TX_OUT !== 1'b1) $display("FAIL basic_idle_tx: TX_OUT %b expected 1", TX_OUT); else pass_cnt++;
   endtask

   task automatic test_parity;
      int lat, exp_len;
      bit tmo;
      logic e;
      for (int t = 0; t < 2; t++) begin
         start_frame(8'h07, 1, t[0], 8);
         record_frame(0, lat, tmo);
         chk_cnt++;
         if (tmo) $display("FAIL parity_timeout: typ %0d timeout %b expected 0", t, tmo); else pass_cnt++;
         exp_len = exp_len_q.pop_front();
         chk_cnt++;
         if (log_q.size() != exp_len)
            $display("FAIL parity_len: typ %0d busy cycles %0d expected %0d", t, log_q.size(), exp_len);
         else pass_cnt++;
         for (int i = 0; i < exp_len; i++) begin
            e = exp_q.pop_front();
            if (i < log_q.size()) begin
               chk_cnt++;
               if (log_q[i] !== e)
                  $display("FAIL parity_bit: typ %0d cycle %0d TX_OUT %b expected %b", t, i, log_q[i], e);
               else pass_cnt++;
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int lat, exp_len;
      bit tmo;
      logic e;
      start_frame(8'hA5, 0, 0, 4);
      fork
         record_frame(1, lat, tmo);
         begin
            repeat (10) @(negedge clk);
            P_DATA   = 8'hFF;
            Prescale = 6'd16;
            PAR_EN   = 1'b1;
            PAR_TYP  = 1'b0;
            push_frame(8'hFF, 1, 0, 16);
         end
      join
      for (int f = 0; f < 2; f++) begin
         if (f == 1) record_frame(0, lat, tmo);
         chk_cnt++;
         if (tmo) $display("FAIL b2b_timeout: frame %0d timeout %b expected 0", f, tmo); else pass_cnt++;
         chk_cnt++;
         if (lat != 1) $display("FAIL b2b_latency: frame %0d %0d expected 1", f, lat); else pass_cnt++;
         exp_len = exp_len_q.pop_front();
         chk_cnt++;
         if (log_q.size() != exp_len)
            $display("FAIL b2b_len: frame %0d busy cycles %0d expected %0d", f, log_q.size(), exp_len);
         else pass_cnt++;
         for (int i = 0; i < exp_len; i++) begin
            e = exp_q.pop_front();
            if (i < log_q.size()) begin
               chk_cnt++;
               if (log_q[i] !== e)
                  $display("FAIL b2b_bit: frame %0d cycle %0d TX_OUT %b expected %b", f, i, log_q[i], e);
               else pass_cnt++;
            end
         end
      end
   endtask

   task automatic test_small_prescale;
      int lat, exp_len;
      bit tmo;
      logic e;
      for (int p = 0; p < 2; p++) begin
         start_frame(8'h3C, 0, 0, p);
         record_frame(0, lat, tmo);
         chk_cnt++;
         if (tmo) $display("FAIL presc_timeout: P %0d timeout %b expected 0", p, tmo); else pass_cnt++;
         exp_len = exp_len_q.pop_front();
         chk_cnt++;
         if (log_q.size() != exp_len)
            $display("FAIL presc_len: P %0d busy cycles %0d expected %0d", p, log_q.size(), exp_len);
         else pass_cnt++;
         for (int i = 0; i < exp_len; i++) begin
            e = exp_q.pop_front();
            if (i < log_q.size()) begin
               chk_cnt++;
               if (log_q[i] !== e)
                  $display("FAIL presc_bit: P %0d cycle %0d TX_OUT %b expected %b", p, i, log_q[i], e);
               else pass_cnt++;
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame;
      int lat, exp_len;
      bit tmo, seen;
      logic e;
      @(negedge clk);
      P_DATA     = 8'hA5;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Prescale   = 6'd4;
      Data_Valid = 1'b1;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (busy === 1'b1) seen = 1;
      end
      Data_Valid = 1'b0;
      chk_cnt++;
      if (!seen) $display("FAIL abort_start: busy %b expected 1", busy); else pass_cnt++;
      // Cycle 17 of the frame lies inside data bit 3 (cycles 16..19 at P=4).
      repeat (17) @(negedge clk);
      chk_cnt++;
      if (TX_OUT !== 1'b0 || busy !== 1'b1)
         $display("FAIL abort_pre: TX_OUT %b busy %b expected 0 1", TX_OUT, busy);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0)
         $display("FAIL abort_post: TX_OUT %b busy %b expected 1 0", TX_OUT, busy);
      else pass_cnt++;
      rst = 1'b1;
      start_frame(8'h5A, 1, 1, 4);
      record_frame(0, lat, tmo);
      chk_cnt++;
      if (tmo || lat != 1) $display("FAIL abort_refr: timeout %b latency %0d expected 0 1", tmo, lat);
      else pass_cnt++;
      exp_len = exp_len_q.pop_front();
      chk_cnt++;
      if (log_q.size() != exp_len)
         $display("FAIL abort_len: busy cycles %0d expected %0d", log_q.size(), exp_len);
      else pass_cnt++;
      for (int i = 0; i < exp_len; i++) begin
         e = exp_q.pop_front();
         if (i < log_q.size()) begin
            chk_cnt++;
            if (log_q[i] !== e) $display("FAIL abort_bit: cycle %0d TX_OUT %b expected %b", i, log_q[i], e);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_small_prescale();
      test_reset_mid_frame();
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
